// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - byte-wide handshaked RAM port between the MEM stage and data memory
interface mem_lsu_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            wdata;
  logic [7:0]            rdata;
  logic                  ack;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output ack
  );
endinterface

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - RV32I MEM stage: byte-serial loads/stores with pipeline stall request
module mem_lsu #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            mem_wd_i,
  input  logic                  mem_wreg_i,
  input  logic [31:0]           mem_wdata_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [31:0]           mem_sdata_i,
  mem_lsu_if.master             ram,
  output logic [4:0]            wb_wd_o,
  output logic                  wb_wreg_o,
  output logic [31:0]           wb_wdata_o,
  output logic                  stall_req_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  logic [1:0]  state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] data_q, data_d;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic [1:0]  last_k;
  logic [31:0] load_val;

  // Decode op into load/store class and index of the final byte (N-1); 9-15 decode as NONE
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    last_k   = 2'd0;
    case (mem_op_i)
      OP_LB, OP_LBU: begin is_load  = 1'b1; last_k = 2'd0; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; last_k = 2'd1; end
      OP_LW:         begin is_load  = 1'b1; last_k = 2'd3; end
      OP_SB:         begin is_store = 1'b1; last_k = 2'd0; end
      OP_SH:         begin is_store = 1'b1; last_k = 2'd1; end
      OP_SW:         begin is_store = 1'b1; last_k = 2'd3; end
      default:       ;
    endcase
  end

  assign is_mem = is_load | is_store;

  // Sign/zero extension of the assembled little-endian load data
  always_comb begin
    load_val = data_q;
    case (mem_op_i)
      OP_LB:   load_val = {{24{data_q[7]}}, data_q[7:0]};
      OP_LBU:  load_val = {24'd0, data_q[7:0]};
      OP_LH:   load_val = {{16{data_q[15]}}, data_q[15:0]};
      OP_LHU:  load_val = {16'd0, data_q[15:0]};
      default: load_val = data_q;
    endcase
  end

  // Next-state logic: one byte per acked transfer, byte index k walks 0..N-1
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (is_mem) begin
          state_d = ST_XFER;
          k_d     = 2'd0;
        end
      end
      ST_XFER: begin
        if (ram.ack) begin
          if (is_load) begin
            data_d[{k_q, 3'b000} +: 8] = ram.rdata;
          end
          if (k_q == last_k) begin
            state_d = ST_DONE;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= 2'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      data_q  <= data_d;
    end
  end

  // Output decode; everything is forced low while rst is asserted, including the RAM request
  always_comb begin
    ram.req     = 1'b0;
    ram.we      = 1'b0;
    ram.addr    = '0;
    ram.wdata   = 8'd0;
    wb_wd_o     = 5'd0;
    wb_wreg_o   = 1'b0;
    wb_wdata_o  = 32'd0;
    stall_req_o = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          wb_wd_o    = mem_wd_i;
          wb_wdata_o = mem_wdata_i;
          if (is_mem) begin
            stall_req_o = 1'b1;
          end else begin
            wb_wreg_o = mem_wreg_i;
          end
        end
        ST_XFER: begin
          stall_req_o = 1'b1;
          ram.req     = 1'b1;
          ram.we      = is_store;
          ram.addr    = mem_addr_i + ADDR_WIDTH'(k_q);
          ram.wdata   = mem_sdata_i[{k_q, 3'b000} +: 8];
          wb_wd_o     = mem_wd_i;
        end
        ST_DONE: begin
          wb_wd_o    = mem_wd_i;
          wb_wreg_o  = mem_wreg_i;
          wb_wdata_o = is_load ? load_val : mem_wdata_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu
module tb_mem_lsu;

  logic        clk;
  logic        rst;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_sdata_i;
  logic [4:0]  wb_wd_o;
  logic        wb_wreg_o;
  logic [31:0] wb_wdata_o;
  logic        stall_req_o;

  int tests_run;
  int tests_failed;

  mem_lsu_if #(.ADDR_WIDTH(32)) ram_if ();

  mem_lsu #(.ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_wd_i    (mem_wd_i),
    .mem_wreg_i  (mem_wreg_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_op_i    (mem_op_i),
    .mem_addr_i  (mem_addr_i),
    .mem_sdata_i (mem_sdata_i),
    .ram         (ram_if),
    .wb_wd_o     (wb_wd_o),
    .wb_wreg_o   (wb_wreg_o),
    .wb_wdata_o  (wb_wdata_o),
    .stall_req_o (stall_req_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete memory op: IDLE cycle, N transfers each with `waits` wait states, then DONE.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic wreg, input int waits,
                        input logic [31:0] rbytes, input logic [31:0] exp_wb);
    int n;
    logic exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_byte;
    n = (op == 4'd1 || op == 4'd4 || op == 4'd6) ? 1 :
        (op == 4'd2 || op == 4'd5 || op == 4'd7) ? 2 : 4;
    exp_we = (op >= 4'd6);
    @(negedge clk);
    mem_op_i    = op;
    mem_addr_i  = addr;
    mem_sdata_i = sdata;
    mem_wd_i    = 5'd7;
    mem_wreg_i  = wreg;
    mem_wdata_i = 32'hA5A5_0000;
    ram_if.ack  = 1'b0;
    #1;
    chk({tag, " idle stall"}, 32'(stall_req_o), 32'd1);
    chk({tag, " idle wreg"}, 32'(wb_wreg_o), 32'd0);
    chk({tag, " idle req"}, 32'(ram_if.req), 32'd0);
    for (int b = 0; b < n; b++) begin
      for (int w = 0; w <= waits; w++) begin
        @(negedge clk);
        ram_if.ack = 1'b0;
        #1;
        exp_addr = addr + 32'(b);
        exp_byte = (sdata >> (8 * b)) & 32'hFF;
        chk($sformatf("%s b%0d w%0d req", tag, b, w), 32'(ram_if.req), 32'd1);
        chk($sformatf("%s b%0d w%0d addr", tag, b, w), ram_if.addr, exp_addr);
        chk($sformatf("%s b%0d w%0d we", tag, b, w), 32'(ram_if.we), 32'(exp_we));
        chk($sformatf("%s b%0d w%0d wdata", tag, b, w), 32'(ram_if.wdata), exp_byte);
        chk($sformatf("%s b%0d w%0d stall", tag, b, w), 32'(stall_req_o), 32'd1);
        chk($sformatf("%s b%0d w%0d wreg", tag, b, w), 32'(wb_wreg_o), 32'd0);
        if (w == waits) begin
          ram_if.ack   = 1'b1;
          ram_if.rdata = 8'((rbytes >> (8 * b)) & 32'hFF);
        end
      end
    end
    @(negedge clk);
    ram_if.ack = 1'b0;
    #1;
    chk({tag, " done stall"}, 32'(stall_req_o), 32'd0);
    chk({tag, " done req"}, 32'(ram_if.req), 32'd0);
    chk({tag, " done wd"}, 32'(wb_wd_o), 32'd7);
    chk({tag, " done wreg"}, 32'(wb_wreg_o), 32'(wreg));
    chk({tag, " done wdata"}, wb_wdata_o, exp_wb);
    @(negedge clk);
    mem_op_i = 4'd0;
    #1;
    chk({tag, " back idle stall"}, 32'(stall_req_o), 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    mem_op_i     = 4'd3;
    mem_addr_i   = 32'h100;
    mem_sdata_i  = 32'hFFFF_FFFF;
    mem_wd_i     = 5'd9;
    mem_wreg_i   = 1'b1;
    mem_wdata_i  = 32'h1111_2222;
    ram_if.ack   = 1'b1;
    ram_if.rdata = 8'h55;

    // Reset: outputs forced to zero regardless of inputs
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst req", 32'(ram_if.req), 32'd0);
    chk("rst stall", 32'(stall_req_o), 32'd0);
    chk("rst wreg", 32'(wb_wreg_o), 32'd0);
    chk("rst wdata", wb_wdata_o, 32'd0);
    chk("rst wd", 32'(wb_wd_o), 32'd0);

    // Pass-through of NONE and of an undefined op
    @(negedge clk);
    rst         = 1'b0;
    ram_if.ack  = 1'b0;
    mem_op_i    = 4'd0;
    mem_wd_i    = 5'd5;
    mem_wreg_i  = 1'b1;
    mem_wdata_i = 32'hDEAD_BEEF;
    #1;
    chk("pass wd", 32'(wb_wd_o), 32'd5);
    chk("pass wreg", 32'(wb_wreg_o), 32'd1);
    chk("pass wdata", wb_wdata_o, 32'hDEAD_BEEF);
    chk("pass stall", 32'(stall_req_o), 32'd0);
    chk("pass req", 32'(ram_if.req), 32'd0);
    @(negedge clk);
    mem_op_i = 4'd12;
    #1;
    chk("op12 wdata", wb_wdata_o, 32'hDEAD_BEEF);
    chk("op12 stall", 32'(stall_req_o), 32'd0);
    mem_op_i = 4'd0;

    run_op("lw",  4'd3, 32'h0000_0100, 32'h0, 1'b1, 0, 32'h1234_5678, 32'h1234_5678);
    run_op("lb",  4'd1, 32'h0000_0010, 32'h0, 1'b1, 0, 32'h0000_0080, 32'hFFFF_FF80);
    run_op("lbu", 4'd4, 32'h0000_0010, 32'h0, 1'b1, 0, 32'h0000_0080, 32'h0000_0080);
    run_op("lh",  4'd2, 32'h0000_0020, 32'h0, 1'b1, 0, 32'h0000_FF80, 32'hFFFF_FF80);
    run_op("lhu", 4'd5, 32'h0000_0020, 32'h0, 1'b1, 0, 32'h0000_FF80, 32'h0000_FF80);
    run_op("sh",  4'd7, 32'h0000_0203, 32'h1234_BEEF, 1'b0, 2, 32'h0, 32'hA5A5_0000);
    run_op("sw",  4'd8, 32'hFFFF_FFFE, 32'h1122_3344, 1'b0, 0, 32'h0, 32'hA5A5_0000);
    run_op("sb",  4'd6, 32'h0000_0040, 32'h0000_00C3, 1'b0, 1, 32'h0, 32'hA5A5_0000);

    // Reset in the middle of an LW after two acked bytes
    @(negedge clk);
    mem_op_i   = 4'd3;
    mem_addr_i = 32'h300;
    mem_wd_i   = 5'd7;
    mem_wreg_i = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      ram_if.ack = 1'b0;
      #1;
      if (b < 2) begin
        chk($sformatf("abort b%0d addr", b), ram_if.addr, 32'h300 + 32'(b));
        ram_if.ack   = 1'b1;
        ram_if.rdata = 8'h99;
      end
    end
    chk("abort pre-rst addr", ram_if.addr, 32'h302);
    rst = 1'b1;
    #1;
    chk("abort rst req", 32'(ram_if.req), 32'd0);
    chk("abort rst addr", ram_if.addr, 32'd0);
    chk("abort rst stall", 32'(stall_req_o), 32'd0);
    chk("abort rst wreg", 32'(wb_wreg_o), 32'd0);
    chk("abort rst wdata", wb_wdata_o, 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    mem_op_i = 4'd0;
    run_op("lw after rst", 4'd3, 32'h0000_0400, 32'h0, 1'b1, 0, 32'hCAFE_BABE, 32'hCAFE_BABE);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
